// File: rtl/burst_gen_if.sv
// Handshake, configuration and status bundle for burst_gen.
// BURST_GEN_REPEAT_EN adds the rpt configuration bit.
interface burst_gen_if #(
    parameter int PERIOD_W = 8,
    parameter int COUNT_W  = 8
);
    logic                start;
    logic                abort;
    logic [PERIOD_W-1:0] high_clks;
    logic [PERIOD_W-1:0] low_clks;
    logic [PERIOD_W-1:0] delay_clks;
    logic [COUNT_W-1:0]  pulses;
`ifdef BURST_GEN_REPEAT_EN
    logic                rpt;
`endif
    logic                out;
    logic                busy;
    logic                done;
    logic [COUNT_W-1:0]  pulse_idx;

`ifdef BURST_GEN_REPEAT_EN
    modport master (
        output start, abort, high_clks, low_clks, delay_clks, pulses, rpt,
        input  out, busy, done, pulse_idx
    );
    modport slave (
        input  start, abort, high_clks, low_clks, delay_clks, pulses, rpt,
        output out, busy, done, pulse_idx
    );
`else
    modport master (
        output start, abort, high_clks, low_clks, delay_clks, pulses,
        input  out, busy, done, pulse_idx
    );
    modport slave (
        input  start, abort, high_clks, low_clks, delay_clks, pulses,
        output out, busy, done, pulse_idx
    );
`endif
endinterface

// File: rtl/burst_gen.sv
// Programmable pulse-burst generator: optional delay, then N HIGH/LOW pulses.
// Define BURST_GEN_REPEAT_EN to add the rpt input for continuously repeating bursts.
module burst_gen #(
    parameter int   PERIOD_W   = 8,
    parameter int   COUNT_W    = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic       clk,
    input  logic       n_reset,
    burst_gen_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

    localparam logic [PERIOD_W-1:0] P_ZERO = {PERIOD_W{1'b0}};
    localparam logic [PERIOD_W-1:0] P_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0]  C_ZERO = {COUNT_W{1'b0}};
    localparam logic [COUNT_W-1:0]  C_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    logic [PERIOD_W-1:0] cnt_r;
    logic [PERIOD_W-1:0] high_r;
    logic [PERIOD_W-1:0] low_r;
    logic [PERIOD_W-1:0] delay_r;
    logic [COUNT_W-1:0]  pulses_r;
    logic [COUNT_W-1:0]  pulse_idx_r;
    logic                out_r;
    logic                busy_r;
    logic                done_r;
`ifdef BURST_GEN_REPEAT_EN
    logic                rpt_r;
`endif

    // A programmed phase length of zero still occupies one clock.
    function automatic logic [PERIOD_W-1:0] eff_len(input logic [PERIOD_W-1:0] v);
        eff_len = (v == P_ZERO) ? P_ONE : v;
    endfunction

    function automatic state_t first_state(input logic [PERIOD_W-1:0] d);
        first_state = (d != P_ZERO) ? ST_DELAY : ST_HIGH;
    endfunction

    // cnt_r holds the remaining clocks of the current phase minus one.
    function automatic logic [PERIOD_W-1:0] first_cnt(input logic [PERIOD_W-1:0] d,
                                                       input logic [PERIOD_W-1:0] h);
        first_cnt = (d != P_ZERO) ? (d - P_ONE) : (eff_len(h) - P_ONE);
    endfunction

    function automatic logic first_out(input logic [PERIOD_W-1:0] d);
        first_out = (d != P_ZERO) ? IDLE_LEVEL : ~IDLE_LEVEL;
    endfunction

    // Burst sequencer: state, phase counter, latched config and registered outputs.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= P_ZERO;
            high_r      <= P_ZERO;
            low_r       <= P_ZERO;
            delay_r     <= P_ZERO;
            pulses_r    <= C_ZERO;
            pulse_idx_r <= C_ZERO;
            out_r       <= IDLE_LEVEL;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
`ifdef BURST_GEN_REPEAT_EN
            rpt_r       <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            if (bus.abort && (state_r != ST_IDLE)) begin
                state_r     <= ST_IDLE;
                cnt_r       <= P_ZERO;
                pulse_idx_r <= C_ZERO;
                out_r       <= IDLE_LEVEL;
                busy_r      <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            high_r      <= bus.high_clks;
                            low_r       <= bus.low_clks;
                            delay_r     <= bus.delay_clks;
                            pulses_r    <= bus.pulses;
`ifdef BURST_GEN_REPEAT_EN
                            rpt_r       <= bus.rpt;
`endif
                            pulse_idx_r <= C_ZERO;
                            busy_r      <= 1'b1;
                            // An empty burst spends one busy clock in DELAY, then completes.
                            if (bus.pulses == C_ZERO) begin
                                state_r <= ST_DELAY;
                                cnt_r   <= P_ZERO;
                                out_r   <= IDLE_LEVEL;
                            end else begin
                                state_r <= first_state(bus.delay_clks);
                                cnt_r   <= first_cnt(bus.delay_clks, bus.high_clks);
                                out_r   <= first_out(bus.delay_clks);
                            end
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_DELAY: begin
                        if (pulses_r == C_ZERO) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            out_r   <= IDLE_LEVEL;
                        end else if (cnt_r == P_ZERO) begin
                            state_r <= ST_HIGH;
                            cnt_r   <= eff_len(high_r) - P_ONE;
                            out_r   <= ~IDLE_LEVEL;
                        end else begin
                            cnt_r <= cnt_r - P_ONE;
                        end
                    end
                    ST_HIGH: begin
                        if (cnt_r == P_ZERO) begin
                            state_r <= ST_LOW;
                            cnt_r   <= eff_len(low_r) - P_ONE;
                            out_r   <= IDLE_LEVEL;
                        end else begin
                            cnt_r <= cnt_r - P_ONE;
                        end
                    end
                    ST_LOW: begin
                        if (cnt_r != P_ZERO) begin
                            cnt_r <= cnt_r - P_ONE;
                        end else if (pulse_idx_r != (pulses_r - C_ONE)) begin
                            state_r     <= ST_HIGH;
                            pulse_idx_r <= pulse_idx_r + C_ONE;
                            cnt_r       <= eff_len(high_r) - P_ONE;
                            out_r       <= ~IDLE_LEVEL;
                        end else begin
                            done_r      <= 1'b1;
                            pulse_idx_r <= C_ZERO;
`ifdef BURST_GEN_REPEAT_EN
                            if (rpt_r) begin
                                state_r <= first_state(delay_r);
                                cnt_r   <= first_cnt(delay_r, high_r);
                                out_r   <= first_out(delay_r);
                            end else begin
                                state_r <= ST_IDLE;
                                cnt_r   <= P_ZERO;
                                out_r   <= IDLE_LEVEL;
                                busy_r  <= 1'b0;
                            end
`else
                            state_r <= ST_IDLE;
                            cnt_r   <= P_ZERO;
                            out_r   <= IDLE_LEVEL;
                            busy_r  <= 1'b0;
`endif
                        end
                    end
                    default: begin
                        state_r     <= ST_IDLE;
                        cnt_r       <= P_ZERO;
                        pulse_idx_r <= C_ZERO;
                        out_r       <= IDLE_LEVEL;
                        busy_r      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.out       = out_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pulse_idx = pulse_idx_r;

endmodule

// File: tb/tb_burst_gen.sv
// Self-checking bench for burst_gen: per-cycle comparison against a waveform-list
// model, plus hand-computed totals and latencies for each directed scenario.
module tb_burst_gen;
    localparam int   PW = 8;
    localparam int   CW = 8;
    localparam logic IL = 1'b0;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    burst_gen_if #(.PERIOD_W(PW), .COUNT_W(CW)) bus();

    burst_gen #(.PERIOD_W(PW), .COUNT_W(CW), .IDLE_LEVEL(IL)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    typedef struct packed {
        logic          o;
        logic          b;
        logic          d;
        logic [CW-1:0] idx;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   dflag;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;
    int   busy_cycles, high_cycles, done_cnt, rises;
    logic prev_out;

    function automatic exp_t idle_e();
        exp_t e;
        e.o = IL; e.b = 1'b0; e.d = 1'b0; e.idx = '0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic void push(input logic o, input logic b, input int idx);
        exp_t e;
        e.o = o; e.b = b; e.d = dflag; e.idx = idx[CW-1:0];
        q.push_back(e);
        dflag = 1'b0;
    endfunction

    // Expected cycle-by-cycle list for a burst accepted with the given config.
    task automatic build(input int h, input int l, input int d, input int p, input int r);
        int reps = (r != 0 && p != 0) ? 40 : 1;
        int he = (h == 0) ? 1 : h;
        int le = (l == 0) ? 1 : l;
        for (int rep = 0; rep < reps; rep++) begin
            dflag = (rep > 0);
            if (p == 0) push(IL, 1'b1, 0);
            else begin
                for (int i = 0; i < d; i++) push(IL, 1'b1, 0);
                for (int k = 0; k < p; k++) begin
                    for (int i = 0; i < he; i++) push(~IL, 1'b1, k);
                    for (int i = 0; i < le; i++) push(IL, 1'b1, k);
                end
            end
        end
        if (reps == 1) begin
            dflag = 1'b1;
            push(IL, 1'b0, 0);
        end
    endtask

    // Model: advance the expected outputs on every rising edge.
    always @(posedge clk) begin
        int r;
        r = 0;
`ifdef BURST_GEN_REPEAT_EN
        r = int'(bus.rpt);
`endif
        if (!n_reset) begin
            q.delete();
            cur = idle_e();
        end else if (cur.b && bus.abort) begin
            q.delete();
            cur = idle_e();
        end else if (!cur.b && bus.start && !bus.abort) begin
            q.delete();
            build(int'(bus.high_clks), int'(bus.low_clks), int'(bus.delay_clks),
                  int'(bus.pulses), r);
            cur = q.pop_front();
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else begin
            cur = idle_e();
        end
    end

    // Compare and tally on the falling edge, away from output updates.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out", bus.out, cur.o);
            chk("busy", bus.busy, cur.b);
            chk("done", bus.done, cur.d);
            chk("pulse_idx", bus.pulse_idx, cur.idx);
            if (bus.busy) busy_cycles++;
            if (bus.out !== IL) high_cycles++;
            if (bus.done) done_cnt++;
            if ((bus.out !== IL) && (prev_out === IL)) rises++;
            prev_out = bus.out;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clr_mon();
        busy_cycles = 0; high_cycles = 0; done_cnt = 0; rises = 0;
    endtask

    task automatic cfg(input int h, input int l, input int d, input int p);
        bus.high_clks  = h[PW-1:0];
        bus.low_clks   = l[PW-1:0];
        bus.delay_clks = d[PW-1:0];
        bus.pulses     = p[CW-1:0];
    endtask

    // Pulse start for one accepting edge and count cycles until done shows.
    task automatic fire(output int lat);
        int n;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 3000) begin
            step(1);
            n++;
        end
        chk("done_timeout", (n >= 3000), 0);
        lat = n;
    endtask

    task automatic settle();
        int n = 0;
        while ((bus.busy || bus.done) && n < 3000) begin
            step(1);
            n++;
        end
        chk("settle_timeout", (n >= 3000), 0);
        step(2);
    endtask

    initial begin
        int lat;
        int n;
        bus.start = 1'b1;
        bus.abort = 1'b1;
`ifdef BURST_GEN_REPEAT_EN
        bus.rpt = 1'b0;
`endif
        cfg(2, 2, 0, 3);
        cur = idle_e();
        prev_out = IL;
        clr_mon();
        step(1);
        chk_en = 1'b1;
        step(2);
        chk("rst_out", bus.out, IL);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_idx", bus.pulse_idx, 0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        n_reset = 1'b1;
        step(2);

        // Basic 2H2L x3
        clr_mon();
        cfg(2, 2, 0, 3);
        fire(lat);
        chk("basic_lat", lat, 13);
        chk("basic_busy", busy_cycles, 12);
        chk("basic_high", high_cycles, 6);
        chk("basic_rises", rises, 3);
        settle();
        chk("basic_done", done_cnt, 1);

        // Delay 3 with zero phase lengths
        clr_mon();
        cfg(0, 0, 3, 2);
        fire(lat);
        chk("dly_lat", lat, 8);
        chk("dly_busy", busy_cycles, 7);
        chk("dly_high", high_cycles, 2);
        settle();

        // Abort during the second HIGH
        clr_mon();
        cfg(2, 2, 0, 3);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        n = 0;
        while (!((bus.out !== IL) && (bus.pulse_idx == 8'd1)) && n < 100) begin
            step(1);
            n++;
        end
        chk("abort_reach", (n >= 100), 0);
        bus.abort = 1'b1;
        step(1);
        bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_idx", bus.pulse_idx, 0);
        step(5);
        chk("abort_done", done_cnt, 0);

        // Start and abort together in IDLE
        clr_mon();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step(1);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        step(3);
        chk("sa_busy", busy_cycles, 0);
        chk("sa_done", done_cnt, 0);

        // Start held while busy is ignored
        clr_mon();
        cfg(1, 1, 0, 2);
        bus.start = 1'b1;
        step(4);
        bus.start = 1'b0;
        settle();
        chk("sb_busy", busy_cycles, 4);
        chk("sb_done", done_cnt, 1);

        // Config changed mid-burst has no effect
        clr_mon();
        cfg(2, 1, 0, 2);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        cfg(5, 5, 2, 9);
        n = 1;
        while (!bus.done && n < 200) begin
            step(1);
            n++;
        end
        chk("chg_lat", n, 7);
        chk("chg_busy", busy_cycles, 6);
        settle();

        // Zero pulses
        clr_mon();
        cfg(3, 3, 2, 0);
        fire(lat);
        chk("zero_lat", lat, 2);
        chk("zero_busy", busy_cycles, 1);
        chk("zero_high", high_cycles, 0);
        settle();
        chk("zero_done", done_cnt, 1);

        // Maximum pulse count
        clr_mon();
        cfg(1, 0, 0, 255);
        fire(lat);
        chk("max_lat", lat, 511);
        chk("max_rises", rises, 255);
        chk("max_busy", busy_cycles, 510);
        settle();

        // Reset mid-burst
        clr_mon();
        cfg(3, 3, 0, 4);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(4);
        n_reset = 1'b0;
        step(1);
        n_reset = 1'b1;
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_out", bus.out, IL);
        step(5);
        chk("mrst_done", done_cnt, 0);

`ifdef BURST_GEN_REPEAT_EN
        // Repeating 1H1L x2
        clr_mon();
        cfg(1, 1, 0, 2);
        bus.rpt = 1'b1;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        bus.rpt = 1'b0;
        step(19);
        chk("rpt_done", done_cnt, 4);
        chk("rpt_busy", busy_cycles, 20);
        chk("rpt_rises", rises, 10);
        bus.abort = 1'b1;
        step(1);
        bus.abort = 1'b0;
        clr_mon();
        step(6);
        chk("rpt_abort_busy", busy_cycles, 0);
        chk("rpt_abort_done", done_cnt, 0);
`endif

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/burst_gen.md
BURST_GEN -- requirements
Module: burst_gen

Interface
REQ-001 Parameter PERIOD_W, default 8, SHALL set the width of high_clks, low_clks and delay_clks.
REQ-002 Parameter COUNT_W, default 8, SHALL set the width of pulses and pulse_idx.
REQ-003 Parameter IDLE_LEVEL, default 0, SHALL set the out level when not in a HIGH phase.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 n_reset  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  burst request; accepted only in IDLE.
REQ-007 abort  in  1  terminates any burst in progress.
REQ-008 high_clks  in  PERIOD_W  HIGH phase length in clocks.
REQ-009 low_clks  in  PERIOD_W  LOW phase length in clocks.
REQ-010 delay_clks  in  PERIOD_W  clocks between accept and first HIGH.
REQ-011 pulses  in  COUNT_W  pulses per burst.
REQ-012 out  out  1  pulse output.
REQ-013 busy  out  1  high in any state except IDLE.
REQ-014 done  out  1  one-clock strobe at normal burst completion.
REQ-015 pulse_idx  out  COUNT_W  index of the current pulse, 0-based; 0 in IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, DELAY, HIGH, LOW, with out = ~IDLE_LEVEL only in HIGH.
REQ-017 high_clks, low_clks, delay_clks and pulses SHALL be latched on the accepting edge; later input changes SHALL NOT affect the running burst.
REQ-018 start high in IDLE at edge k SHALL move the FSM to DELAY (latched delay_clks>0) or HIGH (delay_clks=0) at edge k, so busy is high from cycle k+1.
REQ-019 DELAY SHALL last exactly delay_clks cycles, then go to HIGH.
REQ-020 HIGH SHALL last exactly high_clks cycles and LOW exactly low_clks cycles; a latched value of 0 SHALL be treated as 1.
REQ-021 From LOW the FSM SHALL go to HIGH with pulse_idx incremented, or to IDLE if pulse_idx = pulses-1; the final LOW phase SHALL always run in full.
REQ-022 When the FSM enters IDLE from LOW, done SHALL be high for exactly the first IDLE cycle.
REQ-023 Latched pulses = 0 SHALL accept start, go straight to IDLE on the next edge with out never asserted, and pulse done for one cycle.
REQ-024 start while busy SHALL be ignored, with no queuing.
REQ-025 abort high in any non-IDLE state SHALL force IDLE on the next edge: out = IDLE_LEVEL, pulse_idx = 0, done not asserted.
REQ-026 abort and start high together in IDLE SHALL leave the FSM in IDLE, so abort wins.
REQ-027 Counters SHALL not wrap; with pulses = 2^COUNT_W-1 exactly that many pulses SHALL be emitted.

Reset
REQ-028 n_reset low at a clock edge SHALL force IDLE: out = IDLE_LEVEL, busy = 0, done = 0, pulse_idx = 0, all counters and latched config = 0, overriding start and abort.
REQ-029 Reset mid-burst SHALL take effect on that edge, with no done strobe.

Configuration
REQ-030 Macro BURST_GEN_REPEAT_EN defined SHALL add the 1-bit input rpt, latched with the other config on accept.
REQ-031 With BURST_GEN_REPEAT_EN and latched rpt = 1, the FSM SHALL, after the final LOW, pulse done for one cycle, reset pulse_idx to 0, and re-enter DELAY or HIGH per REQ-018 without visiting IDLE; busy stays high and only abort or reset ends the burst.
REQ-032 Without BURST_GEN_REPEAT_EN, the rpt port SHALL be absent and every burst SHALL be single-shot.

Verification
REQ-033 Reset values: hold n_reset low for 3 cycles -> out = IDLE_LEVEL, busy = 0, done = 0, pulse_idx = 0.
REQ-034 Basic burst: high = 2, low = 2, delay = 0, pulses = 3, start for one cycle -> out shows 2H2L x3, busy for 12 cycles, done for one cycle after, 12 cycles after accept.
REQ-035 Delay and zero handling: delay = 3, high = 0, low = 0, pulses = 2 -> 3 cycles low, then H L H L, done.
REQ-036 Abort and collisions:
- abort in the 2nd HIGH -> IDLE next edge, no done;
- start and abort together in IDLE -> stays IDLE;
- start while busy -> ignored;
- inputs changed mid-burst -> waveform unchanged.
REQ-037 Edge counts: pulses = 0 -> done one cycle after accept, out never asserted; pulses = 255 with COUNT_W = 8 -> exactly 255 pulses.
REQ-038 With BURST_GEN_REPEAT_EN: rpt = 1, pulses = 2, high = 1, low = 1 -> continuous 1H1L, done every 4 cycles, busy stays high; abort -> IDLE with no further done.
